// File: rtl/ctr_pkg.sv
// Shared types and constants for the ctrn step counter family.
package ctr_pkg;

  localparam int unsigned CTR_DEFAULT_WIDTH = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } ctr_dir_t;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } ctr_mode_t;

endpackage : ctr_pkg

// File: rtl/ctr_addsub.sv
// Combinational add/subtract with carry-out (carry on add, borrow on subtract).
// Ports:
//   a, b    operands, WIDTH bits, unsigned
//   sub     0 = a+b, 1 = a-b
//   result  low WIDTH bits of the sum/difference
//   co      carry out (add) or borrow out (sub)
module ctr_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             co
);

  logic [WIDTH:0] ext_sum;

  // One extra bit: on subtract the top bit of the zero-extended difference is the borrow.
  always_comb begin
    ext_sum = '0;
    if (sub) begin
      ext_sum = {1'b0, a} - {1'b0, b};
    end else begin
      ext_sum = {1'b0, a} + {1'b0, b};
    end
  end

  assign result = ext_sum[WIDTH-1:0];
  assign co     = ext_sum[WIDTH];

endmodule : ctr_addsub

// File: rtl/ctrn.sv
// Parametrised step counter/accumulator with wrap/saturate, synchronous load,
// overflow pulse, sticky overflow flag and registered compare match.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low reset
//   en, load, d  count enable, synchronous load (priority over en), load value
//   x, dir, sat  step magnitude, 0=up/1=down, 0=wrap/1=saturate
//   cmp, clr_ovf compare value, clear sticky overflow
//   y, ovf, ovf_sticky, match   registered outputs
module ctrn
  import ctr_pkg::*;
#(
  parameter int unsigned WIDTH = CTR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] x,
  input  logic             dir,
  input  logic             sat,
  input  logic [WIDTH-1:0] cmp,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic             match
);

  ctr_dir_t  dir_e;
  ctr_mode_t mode_e;

  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic             match_q, match_d;

  logic [WIDTH-1:0] as_result;
  logic             as_co;
  logic [WIDTH-1:0] clamp_val;

  assign dir_e  = ctr_dir_t'(dir);
  assign mode_e = ctr_mode_t'(sat);

  ctr_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a      (y_q),
    .b      (x),
    .sub    (dir_e == DIR_DOWN),
    .result (as_result),
    .co     (as_co)
  );

  // Saturation rail depends on direction: all-ones going up, zero going down.
  assign clamp_val = (dir_e == DIR_DOWN) ? '0 : '1;

  // Next-state: load > en > hold; sticky set beats clear; match tracks y_d.
  always_comb begin
    y_d      = y_q;
    ovf_d    = 1'b0;
    sticky_d = sticky_q;
    match_d  = 1'b0;

    if (load) begin
      y_d = d;
    end else if (en) begin
      ovf_d = as_co;
      if (as_co && (mode_e == MODE_SAT)) begin
        y_d = clamp_val;
      end else begin
        y_d = as_result;
      end
    end

    if (ovf_d) begin
      sticky_d = 1'b1;
    end else if (clr_ovf) begin
      sticky_d = 1'b0;
    end

    match_d = (y_d == cmp);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      match_q  <= match_d;
    end
  end

  assign y          = y_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;
  assign match      = match_q;

endmodule : ctrn

// File: doc/ctrn.md
# ctrn

Parametrised step counter/accumulator, successor to the fixed 8-bit counter. On each enabled cycle it adds or subtracts a step input. Wrap or saturate behaviour is selectable per cycle. It also provides a synchronous load, an overflow pulse with a sticky flag, and a registered compare-match output. Intended as the reusable counter primitive for timer, address and event-count logic in the layout exercises.

## Interface
Parameters:
- WIDTH, 8, counter/step/load/compare width (≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  count enable
- load  in  1  synchronous load of d
- d  in  WIDTH  load value
- x  in  WIDTH  step magnitude (unsigned)
- dir  in  1  0 = up (y+x), 1 = down (y−x)
- sat  in  1  0 = wrap modulo 2^WIDTH, 1 = saturate
- cmp  in  WIDTH  compare value
- clr_ovf  in  1  clear sticky overflow flag
- y  out  WIDTH  counter value (registered)
- ovf  out  1  one-cycle pulse: overflow/underflow occurred on the update producing current y
- ovf_sticky  out  1  latched overflow flag
- match  out  1  registered, high when y == cmp

## Operation
- Reset values while reset is low: y=0, ovf=0, ovf_sticky=0, match=0. Reset takes effect immediately, without waiting for a clock edge.
- Per-edge priority: load > en > hold.
- load=1:
  - y←d, ovf←0.
  - en, x, dir and sat are ignored.
- en=1, load=0, dir=0:
  - s = {1'b0,y} + {1'b0,x}, computed at WIDTH+1 bits.
  - Carry s[WIDTH]=1 gives ovf←1.
  - y←s[WIDTH-1:0] when sat=0; y←2^WIDTH−1 when sat=1.
  - No carry gives y←s[WIDTH-1:0], ovf←0.
- en=1, load=0, dir=1:
  - Borrow when x > y gives ovf←1.
  - y←(y−x) mod 2^WIDTH when sat=0; y←0 when sat=1.
  - No borrow gives y←y−x, ovf←0.
- en=0, load=0: y holds, ovf←0.
- x=0 with en=1: y unchanged, ovf←0.
- Saturated value plus a further step in the same direction: y stays clamped and ovf pulses again on every such cycle.
- ovf_sticky:
  - Set on any edge where ovf is set.
  - Otherwise cleared when clr_ovf=1.
  - Set wins over clr_ovf in the same cycle.
- match ← (y_next == cmp) on every edge, including hold and load edges. match is therefore aligned with y.

## Timing
- Input to y/ovf/match latency: 1 clock edge.
- cmp change with y held: match updates at the next edge, 1-cycle latency.
- clr_ovf: ovf_sticky falls at the next edge.
- Reset deassertion: the first update occurs at the first rising edge after reset goes high. Synchronising reset release is the integrator's responsibility.
- Reset asserted mid-operation: all outputs return to reset values immediately. No partial update survives.
- No combinational path from any input to any output.

## Structure
- Package ctr_pkg contains:
  - typedef enum logic {DIR_UP=0, DIR_DOWN=1} ctr_dir_t
  - typedef enum logic {MODE_WRAP=0, MODE_SAT=1} ctr_mode_t
  - constant CTR_DEFAULT_WIDTH = 8
- ctrn imports ctr_pkg and casts dir/sat to these types internally. Ports stay plain logic for netlist compatibility.
- One natural combinational sub-module, ctr_addsub (WIDTH parameter):
  - Inputs: a, b, sub.
  - Outputs: result[WIDTH-1:0] and co (carry, or borrow when sub=1).
- ctrn holds the registers, priority mux, clamp logic, sticky flag and compare.

## Test plan
All scenarios use WIDTH=8.
1. Reset low 3 cycles, then en=1, x=1, dir=0, sat=0 for 256 cycles. Required: y steps 1…255 then 0. ovf pulses exactly once, on the 255→0 edge. ovf_sticky=1 afterwards.
2. Load d=250, then en=1, x=10, dir=0, sat=1 for 2 cycles. Required: y=255 with ovf=1, then y=255 with ovf=1 again. Then clr_ovf=1 with en=0: ovf_sticky falls to 0 the next cycle.
3. Load d=3, then en=1, x=5, dir=1. Required: sat=0 gives y=254 with ovf=1. Repeating with sat=1 gives y=0 with ovf=1. With x=3, sat=1: y=0 and ovf=0 (exact zero is not underflow).
4. load=1, d=0x42 with en=1, x=7 in the same cycle. Required: y=0x42, ovf=0. With cmp=0x42, match=1 in the same cycle y becomes 0x42.
5. clr_ovf=1 on an overflowing edge (y=255, x=1, up, wrap). Required: y=0, ovf=1, ovf_sticky=1 (set wins over clear).
6. Counting at y=0x80: drive reset low between clock edges. Required: y=0, ovf=0, ovf_sticky=0, match=0 before the next rising edge. After release, counting resumes from 0.
